riscv_test_monitor: RTL

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

---
 rtl/riscv_test_monitor.sv | 119 +++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// Snoops CPU write-back to x3/x26/x27 and reports PASS/FAIL of a test.
// Define TEST_MON_WATCHDOG_EN to add the RUN-state TIMEOUT watchdog.
module riscv_test_monitor #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [31:0] fail_testnum,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    RUN, SETTLE, PASS, FAIL, TIMEOUT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] sh_x3, sh_x26, sh_x27;
  logic [7:0]  settle, settle_nxt;
  logic [31:0] cyc_nxt, fnum_nxt;
  logic        done_nxt, pass_nxt;
  logic        live;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 32'd1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  assign live = (state == RUN) || (state == SETTLE);

`ifdef TEST_MON_WATCHDOG_EN
  logic tmo_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle;
    cyc_nxt    = cycle_count;
    done_nxt   = test_done;
    pass_nxt   = test_pass;
    fnum_nxt   = fail_testnum;
`ifdef TEST_MON_WATCHDOG_EN
    tmo_nxt    = test_timeout;
`endif
    if (live && cycle_count != 32'hFFFF_FFFF)
      cyc_nxt = cycle_count + 32'd1;
    unique case (state)
      RUN: begin
        if (sh_x26 == 32'd1) begin
          state_nxt  = SETTLE;
          settle_nxt = 8'(SETTLE_CYCLES);
        end
`ifdef TEST_MON_WATCHDOG_EN
        // x26==1 outranks the watchdog on the same edge
        else if (cycle_count == TIMEOUT_CYCLES) begin
          state_nxt = TIMEOUT;
          done_nxt  = 1'b1;
          tmo_nxt   = 1'b1;
          cyc_nxt   = cycle_count;
        end
`endif
      end
      SETTLE: begin
        settle_nxt = settle - 8'd1;
        if (settle == 8'd1) begin
          state_nxt = (sh_x27 == 32'd1) ? PASS : FAIL;
          done_nxt  = 1'b1;
          pass_nxt  = (sh_x27 == 32'd1);
          fnum_nxt  = sh_x3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= RUN;
      settle       <= '0;
      sh_x3        <= '0;
      sh_x26       <= '0;
      sh_x27       <= '0;
      cycle_count  <= '0;
      fail_testnum <= '0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle       <= settle_nxt;
      cycle_count  <= cyc_nxt;
      fail_testnum <= fnum_nxt;
      test_done    <= done_nxt;
      test_pass    <= pass_nxt;
      if (live && wb_en) begin
        if (wb_addr == 5'd3)  sh_x3  <= wb_data;
        if (wb_addr == 5'd26) sh_x26 <= wb_data;
        if (wb_addr == 5'd27) sh_x27 <= wb_data;
      end
    end
  end

`ifdef TEST_MON_WATCHDOG_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) test_timeout <= 1'b0;
    else            test_timeout <= tmo_nxt;
  end
`else
  assign test_timeout = 1'b0;
`endif

endmodule
